sdram_sector_dma: RTL and testbench

- Sequencer that copies one disk sector between the on-chip sector buffer (byte-wide BRAM port) and SDRAM, using the disk port of the SDRAM arbiter.
- Buffer→SDRAM: bytes are packed into aligned dword writes. SDRAM→buffer: byte reads, because the arbiter returns 8 valid bits.
- Sits between the SD-card/host controller and the arbiter, in place of direct ZPU accesses during sector transfers.

---
 rtl/sdram_dma_pkg.sv | 30 +++
 rtl/dma_pack32.sv | 44 ++++
 rtl/sdram_sector_dma.sv | 254 +++++++++++++++++++++++++
 tb/tb_sdram_sector_dma.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_dma_pkg.sv
// ---------------------------------------------------------------------------
// sdram_dma_pkg
// Shared definitions for the sector DMA sequencer:
//   - dma_state_t : sequencer state encoding
//   - DIR_*       : transfer direction encoding of the dir input
//   - lane()      : top bit of the 8-bit lane holding byte i of a dword
//                   (big-endian: byte 0 sits in [31:24])
// ---------------------------------------------------------------------------
package sdram_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WREQ,
        S_WWAIT,
        S_RREQ,
        S_RWAIT,
        S_STORE,
        S_FIN
    } dma_state_t;

    localparam logic DIR_TO_SDRAM = 1'b0;
    localparam logic DIR_TO_BUF   = 1'b1;

    // lane(i) = 31 - 8*i, i in 0..3
    function automatic logic [4:0] lane(input logic [1:0] i);
        return 5'd31 - {i, 3'b000};
    endfunction

endpackage

// File: rtl/dma_pack32.sv
// ---------------------------------------------------------------------------
// dma_pack32
// Collects four bytes into one big-endian dword for an SDRAM write.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear_i     : restart packing at byte 0 (word contents are kept)
//   load_i      : byte_i is the next byte of the dword
//   byte_i      : byte to store
//   word_o      : packed dword; stable while no byte is loaded
//   full_o      : four bytes have been loaded since the last clear
// ---------------------------------------------------------------------------
module dma_pack32
    import sdram_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [2:0]  cnt_q;
    logic [31:0] word_q;

    assign full_o = (cnt_q == 3'd4);
    assign word_o = word_q;

    // Clearing only rewinds the count, so the dword presented to the
    // arbiter stays intact while the sequencer waits outside FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (load_i && !full_o) begin
            word_q[lane(cnt_q[1:0]) -: 8] <= byte_i;
            cnt_q                         <= cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/sdram_sector_dma.sv
// ---------------------------------------------------------------------------
// sdram_sector_dma
// Copies one disk sector between the byte-wide sector buffer and SDRAM via
// the disk port of the SDRAM arbiter.
//   dir=0 : buffer -> SDRAM, aligned big-endian dword writes
//   dir=1 : SDRAM -> buffer, byte reads (any base alignment)
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start, dir,         : transfer request; dir/base_adrs sampled on start,
//   base_adrs             start ignored while busy
//   busy, done, error   : status; done/error are one-cycle pulses
//   buf_addr, buf_q,    : sector buffer port (buf_q valid one cycle after
//   buf_d, buf_we         buf_addr)
//   disk_adrs,          : arbiter request address and write data
//   disk_data_i
//   disk_data_o         : arbiter read data, only [7:0] meaningful
//   disk_write/read     : one-cycle request strobes
//   disk_halfword/byte  : access size qualifiers
//   disk_ram_busy       : arbiter busy, includes the current request
// ---------------------------------------------------------------------------
module sdram_sector_dma
    import sdram_dma_pkg::*;
#(
    parameter int DISK_ABUS_WIDTH = 23,
    parameter int SECTOR_BYTES    = 512,
    parameter int BUF_AW          = 9,
    parameter int TIMEOUT         = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       dir,
    input  logic [DISK_ABUS_WIDTH-1:0] base_adrs,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [BUF_AW-1:0]          buf_addr,
    input  logic [7:0]                 buf_q,
    output logic [7:0]                 buf_d,
    output logic                       buf_we,
    output logic [DISK_ABUS_WIDTH-1:0] disk_adrs,
    output logic [31:0]                disk_data_i,
    input  logic [31:0]                disk_data_o,
    output logic                       disk_write,
    output logic                       disk_read,
    output logic                       disk_halfword,
    output logic                       disk_byte,
    input  logic                       disk_ram_busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT - 1);
    // k of the final dword / final byte; the increment from here wraps k.
    localparam logic [BUF_AW-1:0] K_LAST_WORD = BUF_AW'(SECTOR_BYTES - 4);
    localparam logic [BUF_AW-1:0] K_LAST_BYTE = BUF_AW'(SECTOR_BYTES - 1);

    dma_state_t                 state_q;
    logic [BUF_AW-1:0]          k_q;
    logic [DISK_ABUS_WIDTH-1:0] base_q;
    logic [2:0]                 fcnt_q;
    logic [TMO_W-1:0]           tmo_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       error_q;
    logic [BUF_AW-1:0]          buf_addr_q;
    logic [7:0]                 buf_d_q;
    logic                       buf_we_q;
    logic [DISK_ABUS_WIDTH-1:0] disk_adrs_q;
    logic                       disk_write_q;
    logic                       disk_read_q;
    logic                       disk_byte_q;

    logic [BUF_AW-1:0]          k_plus1_d;
    logic [BUF_AW-1:0]          k_plus4_d;
    logic [DISK_ABUS_WIDTH-1:0] adrs_k_d;
    logic [DISK_ABUS_WIDTH-1:0] adrs_k1_d;
    logic                       pack_clear;
    logic                       pack_load;
    logic                       pack_full;
    logic                       unused_rdata;

    assign k_plus1_d = k_q + BUF_AW'(1);
    assign k_plus4_d = k_q + BUF_AW'(4);
    assign adrs_k_d  = base_q + DISK_ABUS_WIDTH'(k_q);
    assign adrs_k1_d = base_q + DISK_ABUS_WIDTH'(k_plus1_d);

    // The arbiter only returns a byte; upper lanes are don't-care.
    assign unused_rdata = ^disk_data_o[31:8];

    // fcnt_q counts buffer addresses issued; the byte for an address
    // arrives one cycle later, so loading starts from the second cycle.
    assign pack_clear = (state_q != S_FETCH);
    assign pack_load  = (state_q == S_FETCH) && (fcnt_q != 3'd0);

    dma_pack32 u_pack (
        .clk     (clk),
        .reset   (reset),
        .clear_i (pack_clear),
        .load_i  (pack_load),
        .byte_i  (buf_q),
        .word_o  (disk_data_i),
        .full_o  (pack_full)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign buf_addr      = buf_addr_q;
    assign buf_d         = buf_d_q;
    assign buf_we        = buf_we_q;
    assign disk_adrs     = disk_adrs_q;
    assign disk_write    = disk_write_q;
    assign disk_read     = disk_read_q;
    assign disk_byte     = disk_byte_q;
    assign disk_halfword = 1'b0;

    // Request strobes, buf_we, done and error default low every cycle and
    // are set on the transition into the state where they must be seen,
    // which keeps each of them to a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            base_q       <= '0;
            fcnt_q       <= '0;
            tmo_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            buf_addr_q   <= '0;
            buf_d_q      <= '0;
            buf_we_q     <= 1'b0;
            disk_adrs_q  <= '0;
            disk_write_q <= 1'b0;
            disk_read_q  <= 1'b0;
            disk_byte_q  <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            buf_we_q     <= 1'b0;
            disk_write_q <= 1'b0;
            disk_read_q  <= 1'b0;
            disk_byte_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (dir == DIR_TO_SDRAM && base_adrs[1:0] != 2'b00) begin
                            error_q <= 1'b1;
                        end else begin
                            base_q <= base_adrs;
                            k_q    <= '0;
                            busy_q <= 1'b1;
                            if (dir == DIR_TO_BUF) begin
                                state_q     <= S_RREQ;
                                disk_adrs_q <= base_adrs;
                                disk_read_q <= 1'b1;
                                disk_byte_q <= 1'b1;
                            end else begin
                                state_q    <= S_FETCH;
                                buf_addr_q <= '0;
                                fcnt_q     <= '0;
                            end
                        end
                    end
                end

                S_FETCH: begin
                    if (pack_full) begin
                        state_q      <= S_WREQ;
                        disk_adrs_q  <= adrs_k_d;
                        disk_write_q <= 1'b1;
                    end else begin
                        if (fcnt_q < 3'd3) begin
                            buf_addr_q <= buf_addr_q + BUF_AW'(1);
                        end
                        if (fcnt_q != 3'd4) begin
                            fcnt_q <= fcnt_q + 3'd1;
                        end
                    end
                end

                S_WREQ: begin
                    state_q <= S_WWAIT;
                    tmo_q   <= '0;
                end

                S_WWAIT: begin
                    if (!disk_ram_busy) begin
                        k_q <= k_plus4_d;
                        if (k_q == K_LAST_WORD) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_FETCH;
                            buf_addr_q <= k_plus4_d;
                            fcnt_q     <= '0;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end

                S_RREQ: begin
                    state_q <= S_RWAIT;
                    tmo_q   <= '0;
                end

                S_RWAIT: begin
                    if (!disk_ram_busy) begin
                        state_q    <= S_STORE;
                        buf_d_q    <= disk_data_o[7:0];
                        buf_addr_q <= k_q;
                        buf_we_q   <= 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end

                S_STORE: begin
                    k_q <= k_plus1_d;
                    if (k_q == K_LAST_BYTE) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= S_RREQ;
                        disk_adrs_q <= adrs_k1_d;
                        disk_read_q <= 1'b1;
                        disk_byte_q <= 1'b1;
                    end
                end

                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_sector_dma.sv
module tb_sdram_sector_dma;

    localparam int AW  = 23;
    localparam int BAW = 9;
    localparam int TMO = 1023;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          dir;
    logic [AW-1:0] base_adrs;
    logic          busy, done, error;
    logic [BAW-1:0] buf_addr;
    logic [7:0]    buf_q;
    logic [7:0]    buf_d;
    logic          buf_we;
    logic [AW-1:0] disk_adrs;
    logic [31:0]   disk_data_i;
    logic [31:0]   disk_data_o;
    logic          disk_write, disk_read, disk_halfword, disk_byte;
    logic          disk_ram_busy;

    sdram_sector_dma #(
        .DISK_ABUS_WIDTH (AW),
        .SECTOR_BYTES    (512),
        .BUF_AW          (BAW),
        .TIMEOUT         (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dir           (dir),
        .base_adrs     (base_adrs),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .buf_addr      (buf_addr),
        .buf_q         (buf_q),
        .buf_d         (buf_d),
        .buf_we        (buf_we),
        .disk_adrs     (disk_adrs),
        .disk_data_i   (disk_data_i),
        .disk_data_o   (disk_data_o),
        .disk_write    (disk_write),
        .disk_read     (disk_read),
        .disk_halfword (disk_halfword),
        .disk_byte     (disk_byte),
        .disk_ram_busy (disk_ram_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- sector buffer model ----------------
    logic [7:0] buf_mem [0:511];
    int fill_mode = 0;   // 1: buf[n]=n, 2: buf[n]=AA
    always @(posedge clk) begin
        if (fill_mode == 1) begin
            for (int n = 0; n < 512; n++) buf_mem[n] <= 8'(n);
        end else if (fill_mode == 2) begin
            for (int n = 0; n < 512; n++) buf_mem[n] <= 8'hAA;
        end else if (buf_we) begin
            buf_mem[buf_addr] <= buf_d;
        end
        buf_q <= buf_mem[buf_addr];
    end

    // ---------------- arbiter model ----------------
    // busy = request cycle + 2 more cycles (3 total); one chosen access
    // can be stretched to 2000 cycles.
    int unsigned   rem = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            stall_idx = -1;
    logic [AW-1:0] wr_adr [0:4095];
    logic [31:0]   wr_dat [0:4095];
    logic [AW-1:0] rd_adr [0:4095];
    logic [31:0]   rdata = '0;

    always @(posedge clk) begin
        if (disk_write || disk_read) begin
            rem <= ((wr_cnt + rd_cnt) == stall_idx) ? 1999 : 2;
            if (disk_write) begin
                wr_adr[wr_cnt] <= disk_adrs;
                wr_dat[wr_cnt] <= disk_data_i;
                wr_cnt         <= wr_cnt + 1;
            end else begin
                rd_adr[rd_cnt] <= disk_adrs;
                rdata          <= {24'hDEADBE, disk_adrs[7:0]};
                rd_cnt         <= rd_cnt + 1;
            end
        end else if (rem != 0) begin
            rem <= rem - 1;
        end
    end
    assign disk_ram_busy = disk_write | disk_read | (rem != 0);
    assign disk_data_o   = rdata;

    // ---------------- monitor (samples on negedge) ----------------
    int   done_cnt = 0, err_cnt = 0, both_cnt = 0, held_cnt = 0;
    int   qual_bad = 0, we_bad = 0, bcnt = 0, err_bcnt = 0;
    int   last_done_cyc = 0, last_err_cyc = 0, last_busy_cyc = 0;
    logic prev_strobe = 1'b0, busy_p1 = 1'b0, busy_p2 = 1'b0;

    always @(negedge clk) begin
        if (done) begin done_cnt++; last_done_cyc = cyc; end
        if (error) begin err_cnt++; err_bcnt = bcnt; last_err_cyc = cyc; end
        if (done && error) both_cnt++;
        if ((disk_write || disk_read) && prev_strobe) held_cnt++;
        if (disk_write && (disk_byte || disk_halfword)) qual_bad++;
        if (disk_read && (!disk_byte || disk_halfword)) qual_bad++;
        if (buf_we && !(busy_p1 == 1'b0 && busy_p2 == 1'b1)) we_bad++;
        if (disk_ram_busy) last_busy_cyc = cyc;
        if (disk_write || disk_read) bcnt = 1;
        else if (disk_ram_busy) bcnt++;
        prev_strobe = disk_write | disk_read;
        busy_p2     = busy_p1;
        busy_p1     = disk_ram_busy;
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int m);
        @(posedge clk); #1; fill_mode = m;
        @(posedge clk); #1; fill_mode = 0;
    endtask

    task automatic do_start(input logic d, input logic [AW-1:0] b, output int sc);
        @(posedge clk); #1;
        start = 1'b1; dir = d; base_adrs = b; sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) chk(tag, 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_arb_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!disk_ram_busy) begin ok = 1'b1; break; end
        end
        if (!ok) chk(tag, 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_writes(input string tag, input int wb);
        chk({tag, "_cnt"}, 64'(wr_cnt - wb), 64'd128);
        for (int i = 0; i < 128; i++) begin
            logic [7:0] b0;
            b0 = 8'(4 * i);
            chk({tag, "_adr"}, 64'(wr_adr[wb + i]), 64'(32'h100 + 4 * i));
            chk({tag, "_dat"}, 64'(wr_dat[wb + i]),
                64'({b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}));
        end
    endtask

    task automatic check_reads(input string tag, input int rb);
        chk({tag, "_cnt"}, 64'(rd_cnt - rb), 64'd512);
        for (int i = 0; i < 512; i++) begin
            logic [7:0] eb;
            eb = 8'(1 + i);
            chk({tag, "_adr"}, 64'(rd_adr[rb + i]), 64'(32'h201 + i));
            chk({tag, "_buf"}, 64'(buf_mem[i]), 64'(eb));
        end
    endtask

    int sc, sc2, wb, rb, db, eb, wbad, hb, qb;

    initial begin
        reset = 1'b1; start = 1'b0; dir = 1'b0; base_adrs = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_done",   64'(done), 64'd0);
        chk("rst_error",  64'(error), 64'd0);
        chk("rst_bufadr", 64'(buf_addr), 64'd0);
        chk("rst_bufwe",  64'(buf_we), 64'd0);
        chk("rst_dadr",   64'(disk_adrs), 64'd0);
        chk("rst_ddat",   64'(disk_data_i), 64'd0);
        chk("rst_strb",   64'({disk_write, disk_read, disk_halfword, disk_byte}), 64'd0);
        reset = 1'b0;

        // ---- buffer -> SDRAM, base 0x100 ----
        fill(1);
        wb = wr_cnt; db = done_cnt; eb = err_cnt; hb = held_cnt; qb = qual_bad;
        do_start(1'b0, 23'h000100, sc);
        chk("w_busy_up", 64'(busy), 64'd1);
        wait_done("w_done_timeout", 2000);
        check_writes("w", wb);
        chk("w_first_dat", 64'(wr_dat[wb]), 64'h00010203);
        chk("w_latency",  64'(last_done_cyc - sc), 64'd1281);
        chk("w_done_gap", 64'(last_done_cyc - last_busy_cyc), 64'd2);
        chk("w_done_cnt", 64'(done_cnt - db), 64'd1);
        chk("w_err_cnt",  64'(err_cnt - eb), 64'd0);
        chk("w_held",     64'(held_cnt - hb), 64'd0);
        chk("w_qual",     64'(qual_bad - qb), 64'd0);
        chk("w_busy_end", 64'(busy), 64'd0);

        // ---- SDRAM -> buffer, odd base 0x201 ----
        fill(2);
        rb = rd_cnt; db = done_cnt; eb = err_cnt; wbad = we_bad; hb = held_cnt; qb = qual_bad;
        do_start(1'b1, 23'h000201, sc);
        wait_done("r_done_timeout", 4000);
        check_reads("r", rb);
        chk("r_latency",  64'(last_done_cyc - sc), 64'd2561);
        chk("r_we_timing", 64'(we_bad - wbad), 64'd0);
        chk("r_done_cnt", 64'(done_cnt - db), 64'd1);
        chk("r_err_cnt",  64'(err_cnt - eb), 64'd0);
        chk("r_held",     64'(held_cnt - hb), 64'd0);
        chk("r_qual",     64'(qual_bad - qb), 64'd0);

        // ---- misaligned write base ----
        wb = wr_cnt; eb = err_cnt;
        do_start(1'b0, 23'h000102, sc);
        chk("mis_err",  64'(error), 64'd1);
        chk("mis_busy", 64'(busy), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("mis_busy2",   64'(busy), 64'd0);
        chk("mis_writes",  64'(wr_cnt - wb), 64'd0);
        chk("mis_err_cnt", 64'(err_cnt - eb), 64'd1);
        chk("mis_err_lat", 64'(last_err_cyc - sc), 64'd1);

        // ---- timeout on the 5th access ----
        fill(1);
        wb = wr_cnt; db = done_cnt; eb = err_cnt;
        stall_idx = wr_cnt + rd_cnt + 4;
        do_start(1'b0, 23'h000000, sc);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (error) begin ok = 1'b1; break; end
            end
            if (!ok) chk("to_err_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        chk("to_busy_cycles", 64'(err_bcnt), 64'(TMO + 1));
        chk("to_busy",     64'(busy), 64'd0);
        chk("to_done_cnt", 64'(done_cnt - db), 64'd0);
        chk("to_err_cnt",  64'(err_cnt - eb), 64'd1);
        chk("to_writes",   64'(wr_cnt - wb), 64'd5);
        wait_arb_idle("to_arb_timeout");
        stall_idx = -1;
        wb = wr_cnt; db = done_cnt;
        do_start(1'b0, 23'h000100, sc);
        wait_done("to2_done_timeout", 2000);
        check_writes("to2", wb);
        chk("to2_done_cnt", 64'(done_cnt - db), 64'd1);

        // ---- reset during RWAIT of byte 37 ----
        fill(2);
        db = done_cnt; eb = err_cnt;
        do_start(1'b1, 23'h000201, sc);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (disk_read && disk_adrs == 23'(32'h201 + 37)) begin ok = 1'b1; break; end
            end
            if (!ok) chk("rr_find_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rr_busy",   64'(busy), 64'd0);
        chk("rr_bufadr", 64'(buf_addr), 64'd0);
        chk("rr_bufd",   64'(buf_d), 64'd0);
        chk("rr_dadr",   64'(disk_adrs), 64'd0);
        chk("rr_ddat",   64'(disk_data_i), 64'd0);
        chk("rr_flags",  64'({done, error, buf_we, disk_write, disk_read, disk_byte}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        wait_arb_idle("rr_arb_timeout");
        chk("rr_no_done", 64'(done_cnt - db), 64'd0);
        chk("rr_no_err",  64'(err_cnt - eb), 64'd0);
        fill(2);
        rb = rd_cnt; db = done_cnt;
        do_start(1'b1, 23'h000201, sc);
        wait_done("rr2_done_timeout", 4000);
        check_reads("rr2", rb);
        chk("rr2_done_cnt", 64'(done_cnt - db), 64'd1);

        // ---- start pulses during an active transfer ----
        fill(1);
        wb = wr_cnt; db = done_cnt; eb = err_cnt;
        do_start(1'b0, 23'h000100, sc);
        repeat (40)  @(posedge clk);
        do_start(1'b1, 23'h000003, sc2);
        repeat (300) @(posedge clk);
        do_start(1'b0, 23'h000102, sc2);
        repeat (900) @(posedge clk);
        do_start(1'b0, 23'h000000, sc2);
        wait_done("ig_done_timeout", 1000);
        check_writes("ig", wb);
        chk("ig_latency",  64'(last_done_cyc - sc), 64'd1281);
        chk("ig_done_cnt", 64'(done_cnt - db), 64'd1);
        chk("ig_err_cnt",  64'(err_cnt - eb), 64'd0);
        chk("ig_busy_end", 64'(busy), 64'd0);

        chk("done_err_overlap", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
